// File: rtl/lemmings_world_if.sv
// Lemming <-> world handshake: behaviour flags from the lemming, environment flags back to it.
interface lemmings_world_if;
  logic walk_left;
  logic walk_right;
  logic digging;
  logic aaah;
  logic ground;
  logic bump_left;
  logic bump_right;

  modport master (
    output walk_left, walk_right, digging, aaah,
    input  ground, bump_left, bump_right
  );

  // aaah is purely informational and the world never inspects it.
  modport slave (
    input  walk_left, walk_right, digging,
    output ground, bump_left, bump_right
  );
endinterface

// File: rtl/lemmings_world.sv
// Terrain model for a single lemming: a diggable floor row above a bedrock pit,
// with fall timing, landing pulse and a sticky illegal-input flag.
module lemmings_world #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned START_POS  = 8,
  parameter int unsigned DIG_CYCLES = 4,
  parameter int unsigned PIT_DEPTH  = 24,
  localparam int unsigned PW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] floor_init,
  lemmings_world_if.slave  lem,
  output logic [PW-1:0]    pos,
  output logic             level,
  output logic             hit_bottom,
  output logic [7:0]       fall_len,
  output logic             protocol_err
);

  localparam int unsigned DW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

  localparam logic [1:0] StFloor   = 2'd0;
  localparam logic [1:0] StFalling = 2'd1;
  localparam logic [1:0] StBottom  = 2'd2;

  localparam logic [PW-1:0] PosLast   = PW'(WIDTH - 1);
  localparam logic [DW-1:0] DigLast   = DW'(DIG_CYCLES - 1);
  localparam logic [7:0]    FallLast  = 8'(PIT_DEPTH - 1);
  localparam logic [7:0]    FallTotal = 8'(PIT_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [WIDTH-1:0] floor_q, floor_d;
  logic [7:0]       fall_cnt_q, fall_cnt_d;
  logic [DW-1:0]    dig_cnt_q, dig_cnt_d;
  logic             hit_q, hit_d;
  logic [7:0]       fall_len_q, fall_len_d;
  logic             err_q, err_d;

  logic at_left, at_right, standing;

  always_comb begin
    at_left  = (pos_q == '0);
    at_right = (pos_q == PosLast);
    standing = ((state_q == StFloor) && floor_q[pos_q]) || (state_q == StBottom);

    lem.ground     = standing;
    lem.bump_left  = (state_q != StFalling) && at_left;
    lem.bump_right = (state_q != StFalling) && at_right;
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    floor_d    = floor_q;
    fall_cnt_d = fall_cnt_q;
    dig_cnt_d  = dig_cnt_q;
    hit_d      = 1'b0;
    fall_len_d = fall_len_q;
    err_d      = err_q | (lem.walk_left & lem.walk_right) |
                 (lem.digging & (lem.walk_left | lem.walk_right));

    unique case (state_q)
      StFloor, StBottom: begin
        if ((state_q == StFloor) && !floor_q[pos_q]) begin
          // Ground already reads low in this cycle, so the fall counts from 1.
          state_d    = StFalling;
          fall_cnt_d = 8'd1;
          dig_cnt_d  = '0;
        end else if (lem.digging) begin
          if (state_q == StBottom) begin
            dig_cnt_d = '0;
          end else if (dig_cnt_q == DigLast) begin
            floor_d[pos_q] = 1'b0;
            dig_cnt_d      = '0;
          end else begin
            dig_cnt_d = dig_cnt_q + DW'(1);
          end
        end else begin
          dig_cnt_d = '0;
          if (lem.walk_left && !at_left) begin
            pos_d = pos_q - PW'(1);
          end else if (lem.walk_right && !at_right) begin
            pos_d = pos_q + PW'(1);
          end
        end
      end
      StFalling: begin
        if (fall_cnt_q == FallLast) begin
          state_d    = StBottom;
          fall_len_d = FallTotal;
          hit_d      = 1'b1;
          fall_cnt_d = '0;
        end else begin
          fall_cnt_d = fall_cnt_q + 8'd1;
        end
      end
      default: state_d = StFloor;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StFloor;
      pos_q      <= PW'(START_POS);
      floor_q    <= floor_init;
      fall_cnt_q <= '0;
      dig_cnt_q  <= '0;
      hit_q      <= 1'b0;
      fall_len_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      floor_q    <= floor_d;
      fall_cnt_q <= fall_cnt_d;
      dig_cnt_q  <= dig_cnt_d;
      hit_q      <= hit_d;
      fall_len_q <= fall_len_d;
      err_q      <= err_d;
    end
  end

  assign pos          = pos_q;
  assign level        = (state_q == StBottom);
  assign hit_bottom   = hit_q;
  assign fall_len     = fall_len_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_lemmings_world.sv
// Directed bench for lemmings_world: walking, walls, digging, falling, reset and protocol errors.
module tb_lemmings_world;
  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] floor_init;
  logic [3:0]  pos;
  logic        level, hit_bottom, protocol_err;
  logic [7:0]  fall_len;

  int checks = 0;
  int errors = 0;
  int n_low, hits, hit_idx;

  lemmings_world_if lem();

  lemmings_world dut (
    .clk          (clk),
    .resetn       (resetn),
    .floor_init   (floor_init),
    .lem          (lem),
    .pos          (pos),
    .level        (level),
    .hit_bottom   (hit_bottom),
    .fall_len     (fall_len),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] map);
    lem.walk_left  = 1'b0;
    lem.walk_right = 1'b0;
    lem.digging    = 1'b0;
    floor_init     = map;
    resetn         = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // Counts ground-low cycles and landing pulses over a fixed window starting now.
  task automatic measure_fall(output int low, output int pulses, output int idx);
    low = 0; pulses = 0; idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (lem.ground === 1'b0) low++;
      if (hit_bottom === 1'b1) begin
        pulses++;
        idx = i;
      end
      step();
    end
  endtask

  initial begin
    resetn = 1'b0;
    lem.aaah = 1'b0;

    // Reset state and walking to the left wall
    do_reset(16'hFFFF);
    chk("rst_pos", 32'(pos), 32'd8);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_hit", 32'(hit_bottom), 32'd0);
    chk("rst_fall_len", 32'(fall_len), 32'd0);
    chk("rst_err", 32'(protocol_err), 32'd0);
    chk("rst_ground", 32'(lem.ground), 32'd1);
    chk("rst_bumps", {30'd0, lem.bump_left, lem.bump_right}, 32'd0);
    lem.walk_left = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("walk_left_pos", 32'(pos), 32'(8 - i));
    end
    chk("wall_bump_left", 32'(lem.bump_left), 32'd1);
    step();
    chk("wall_pos_hold", 32'(pos), 32'd0);
    chk("wall_ground", 32'(lem.ground), 32'd1);

    // Dig through at column 8, then fall
    do_reset(16'hFFFF);
    lem.digging = 1'b1;
    step(); step(); step();
    chk("dig3_ground", 32'(lem.ground), 32'd1);
    step();
    lem.digging = 1'b0;
    chk("dig4_ground", 32'(lem.ground), 32'd0);
    measure_fall(n_low, hits, hit_idx);
    chk("dig_fall_low", 32'(n_low), 32'd24);
    chk("dig_fall_hits", 32'(hits), 32'd1);
    chk("dig_fall_hit_idx", 32'(hit_idx), 32'd24);
    chk("dig_fall_len", 32'(fall_len), 32'd24);
    chk("dig_fall_level", 32'(level), 32'd1);
    chk("dig_fall_ground", 32'(lem.ground), 32'd1);
    chk("dig_fall_pos", 32'(pos), 32'd8);
    // Bedrock: digging leaves the lemming at the bottom
    lem.digging = 1'b1;
    step(); step(); step(); step(); step();
    lem.digging = 1'b0;
    chk("bedrock_level", 32'(level), 32'd1);
    chk("bedrock_ground", 32'(lem.ground), 32'd1);
    lem.walk_right = 1'b1;
    for (int i = 0; i < 10; i++) step();
    lem.walk_right = 1'b0;
    chk("bottom_right_pos", 32'(pos), 32'd15);
    chk("bottom_bump_right", 32'(lem.bump_right), 32'd1);
    chk("fall_len_held", 32'(fall_len), 32'd24);

    // Walking onto a hole at column 5
    do_reset(16'hFFDF);
    lem.walk_left = 1'b1;
    step(); step();
    chk("hole_ground_pos6", 32'(lem.ground), 32'd1);
    step();
    lem.walk_left = 1'b0;
    chk("hole_pos", 32'(pos), 32'd5);
    chk("hole_ground", 32'(lem.ground), 32'd0);
    measure_fall(n_low, hits, hit_idx);
    chk("hole_fall_low", 32'(n_low), 32'd24);
    chk("hole_hit_idx", 32'(hit_idx), 32'd24);
    chk("hole_land_pos", 32'(pos), 32'd5);
    chk("hole_level", 32'(level), 32'd1);

    // Interrupted digging loses progress
    do_reset(16'hFFFF);
    lem.digging = 1'b1;
    step(); step(); step();
    lem.digging = 1'b0;
    step();
    chk("burst1_ground", 32'(lem.ground), 32'd1);
    lem.digging = 1'b1;
    step(); step(); step();
    chk("burst2_3_ground", 32'(lem.ground), 32'd1);
    step();
    lem.digging = 1'b0;
    chk("burst2_4_ground", 32'(lem.ground), 32'd0);

    // Reset mid-fall (fall_cnt = 10)
    do_reset(16'hFFFF);
    lem.digging = 1'b1;
    step(); step(); step(); step();
    lem.digging = 1'b0;
    for (int i = 0; i < 10; i++) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("midfall_rst_pos", 32'(pos), 32'd8);
    chk("midfall_rst_ground", 32'(lem.ground), 32'd1);
    chk("midfall_rst_level", 32'(level), 32'd0);
    measure_fall(n_low, hits, hit_idx);
    chk("midfall_no_hit", 32'(hits), 32'd0);
    chk("midfall_fall_len", 32'(fall_len), 32'd0);

    // Missing floor under the start column
    do_reset(16'hFEFF);
    chk("start_hole_ground", 32'(lem.ground), 32'd0);
    measure_fall(n_low, hits, hit_idx);
    chk("start_hole_low", 32'(n_low), 32'd24);
    chk("start_hole_hits", 32'(hits), 32'd1);

    // Protocol errors
    do_reset(16'hFFFF);
    lem.walk_left  = 1'b1;
    lem.walk_right = 1'b1;
    step();
    lem.walk_left  = 1'b0;
    lem.walk_right = 1'b0;
    chk("err_set", 32'(protocol_err), 32'd1);
    step(); step();
    chk("err_sticky", 32'(protocol_err), 32'd1);
    do_reset(16'hFFFF);
    chk("err_cleared", 32'(protocol_err), 32'd0);
    lem.digging    = 1'b1;
    lem.walk_right = 1'b1;
    step();
    lem.digging    = 1'b0;
    lem.walk_right = 1'b0;
    chk("err_dig_walk", 32'(protocol_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
